io_serial_bridge: RTL and testbench



---
 rtl/io_bridge_pkg.sv | 20 ++
 rtl/io_serial_bridge_uart_rx.sv | 99 +++++++++
 rtl/io_serial_bridge.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_io_serial_bridge.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the host UART IO bridge.
package io_bridge_pkg;

  localparam logic [2:0] FRAME_MARKER = 3'b101;

  typedef enum logic [1:0] {P_ADDR, P_HI, P_LO, P_CHK} p_state_t;
  typedef enum logic [1:0] {T_IDLE, T_START, T_BITS, T_STOP} t_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} r_state_t;

  // Echo entries are stored at the widest legal geometry; unused bits stay 0.
  typedef struct packed {
    logic [4:0]  idx;
    logic [15:0] data;
  } echo_entry_t;

  function automatic logic [7:0] frame_addr(input logic [4:0] idx);
    return {FRAME_MARKER, idx};
  endfunction

endpackage

// File: rtl/io_serial_bridge_uart_rx.sv
// 8N1 byte receiver: 2-flop synchroniser, start-bit recheck at half bit,
// mid-bit sampling LSB first. byte_valid / stop_err are one-cycle pulses
// issued on the stop-bit sample edge.
//
// state   | meaning
// R_IDLE  | waiting for a falling edge on the synchronised line
// R_START | half-bit wait, then confirm start bit still low
// R_DATA  | sampling 8 data bits mid-bit
// R_STOP  | sampling stop bit, report good byte or framing error
module uart_rx_byte
  import io_bridge_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta, rx_sync, rx_prev;
  r_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg;

  assign byte_data = shreg;
  assign busy      = (state != R_IDLE);

  // Synchronise the async line and keep one more stage for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Receive state machine with a down-counting bit timer.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= R_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
      case (state)
        R_IDLE: begin
          if (rx_prev && !rx_sync) begin
            cnt   <= HALF;
            state <= R_START;
          end
        end
        R_START: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else if (!rx_sync) begin
            cnt     <= FULL;
            bit_idx <= '0;
            state   <= R_DATA;
          end else state <= R_IDLE;
        end
        R_DATA: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            shreg <= {rx_sync, shreg[7:1]};
            cnt   <= FULL;
            if (bit_idx == 3'd7) state <= R_STOP;
            else bit_idx <= bit_idx + 1'b1;
          end
        end
        R_STOP: begin
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            if (rx_sync) byte_valid <= 1'b1;
            else stop_err <= 1'b1;
            state <= R_IDLE;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/io_serial_bridge.sv
// IO register bank shared between the CPU IO ports and a host UART.
// Host frames {101,idx} hi lo write a register; CPU writes are echoed to
// the host in the same frame format through a small queue.
// Optional build macro IO_BRIDGE_CHECKSUM_EN adds a 4th XOR byte to frames
// in both directions; a bad RX checksum drops the frame.
//
// state   | meaning
// P_ADDR  | expecting address byte (marker + index)
// P_HI    | expecting data high byte
// P_LO    | expecting data low byte
// P_CHK   | expecting checksum byte (checksum build only)
// T_IDLE  | line idle, waiting for a queued echo
// T_START | driving start bit
// T_BITS  | driving 8 data bits LSB first
// T_STOP  | driving stop bit, then next byte / next entry
module io_serial_bridge
  import io_bridge_pkg::*;
#(
  parameter int NUM_REGS     = 8,
  parameter int DATA_W       = 15,
  parameter int CLKS_PER_BIT = 434,
  parameter int TXQ_DEPTH    = 4,
  parameter int TIMEOUT_BITS = 20,
  localparam int SEL_W       = $clog2(NUM_REGS) + 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       rx,
  output logic                       tx,
  input  logic [SEL_W-1:0]           IO_read_sel,
  output logic [DATA_W-1:0]          IO_read_data,
  input  logic                       IO_write_en,
  input  logic [SEL_W-1:0]           IO_write_sel,
  input  logic [DATA_W-1:0]          IO_write_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic                       tx_overflow,
  output logic                       rx_frame_err
);

  localparam int IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TO_W     = $clog2(TO_LIMIT + 1);
  localparam int CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int QP_W     = (TXQ_DEPTH > 1) ? $clog2(TXQ_DEPTH) : 1;
  localparam int QC_W     = $clog2(TXQ_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TO_LIMIT);
  localparam logic [QC_W-1:0]  Q_CAP    = QC_W'(TXQ_DEPTH);
`ifdef IO_BRIDGE_CHECKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [7:0] rx_byte;
  logic       rx_valid, rx_stop_err, rx_busy;

  p_state_t          p_state;
  logic [IDX_W-1:0]  p_idx;
  logic [DATA_W-9:0] p_hi;
  logic [TO_W-1:0]   idle_cnt;
`ifdef IO_BRIDGE_CHECKSUM_EN
  logic [7:0]        p_lo;
  logic [7:0]        p_xor;
`endif

  logic              host_we;
  logic [DATA_W-1:0] host_data;
  logic              cpu_we;
  logic [IDX_W-1:0]  cpu_idx;

  echo_entry_t      q [TXQ_DEPTH];
  echo_entry_t      head;
  logic [QP_W-1:0]  q_wr, q_rd;
  logic [QC_W-1:0]  q_cnt;
  logic             push, pop;

  t_state_t         t_state;
  logic [CNT_W-1:0] t_cnt;
  logic [2:0]       t_bit;
  logic [1:0]       t_sel;
  logic [7:0]       t_shift;
  logic [7:0]       cur_byte;

  function automatic logic [QP_W-1:0] ptr_next(input logic [QP_W-1:0] p);
    return (int'(p) == TXQ_DEPTH - 1) ? '0 : p + 1'b1;
  endfunction

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx         (rx),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .stop_err   (rx_stop_err),
    .busy       (rx_busy)
  );

`ifdef IO_BRIDGE_CHECKSUM_EN
  assign host_we   = rx_valid && (p_state == P_CHK) && (rx_byte == p_xor);
  assign host_data = {p_hi, p_lo};
`else
  assign host_we   = rx_valid && (p_state == P_LO);
  assign host_data = {p_hi, rx_byte};
`endif

  assign cpu_we  = IO_write_en && (int'(IO_write_sel) < NUM_REGS);
  assign cpu_idx = IO_write_sel[IDX_W-1:0];

  // Host frame parser with inter-byte idle timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      p_state      <= P_ADDR;
      p_idx        <= '0;
      p_hi         <= '0;
      idle_cnt     <= TO_LOAD;
      rx_frame_err <= 1'b0;
`ifdef IO_BRIDGE_CHECKSUM_EN
      p_lo         <= '0;
      p_xor        <= '0;
`endif
    end else begin
      if (rx_busy || rx_valid || p_state == P_ADDR) idle_cnt <= TO_LOAD;
      else if (idle_cnt != '0) idle_cnt <= idle_cnt - 1'b1;

      if (rx_stop_err) begin
        rx_frame_err <= 1'b1;
        p_state      <= P_ADDR;
      end else if (rx_valid) begin
        case (p_state)
          P_ADDR: begin
            if (rx_byte[7:5] == FRAME_MARKER && int'(rx_byte[4:0]) < NUM_REGS) begin
              p_idx   <= rx_byte[IDX_W-1:0];
              p_state <= P_HI;
`ifdef IO_BRIDGE_CHECKSUM_EN
              p_xor   <= rx_byte;
`endif
            end else rx_frame_err <= 1'b1;
          end
          P_HI: begin
            p_hi    <= rx_byte[DATA_W-9:0];
            p_state <= P_LO;
`ifdef IO_BRIDGE_CHECKSUM_EN
            p_xor   <= p_xor ^ rx_byte;
`endif
          end
          P_LO: begin
`ifdef IO_BRIDGE_CHECKSUM_EN
            p_lo    <= rx_byte;
            p_xor   <= p_xor ^ rx_byte;
            p_state <= P_CHK;
`else
            p_state <= P_ADDR;
`endif
          end
`ifdef IO_BRIDGE_CHECKSUM_EN
          P_CHK: begin
            if (!host_we) rx_frame_err <= 1'b1;
            p_state <= P_ADDR;
          end
`endif
          default: p_state <= P_ADDR;
        endcase
      end else if (p_state != P_ADDR && idle_cnt == '0) begin
        p_state <= P_ADDR;
      end
    end
  end

  // Register bank; a CPU write to the same register overrides a host commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_we) regs[p_idx] <= host_data;
      if (cpu_we) regs[cpu_idx] <= IO_write_data;
    end
  end

  // CPU read port, zero for indices past the bank.
  always_comb begin
    IO_read_data = '0;
    if (int'(IO_read_sel) < NUM_REGS) IO_read_data = regs[IO_read_sel[IDX_W-1:0]];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs[g];
  end

  // The head entry stays queued until its last byte's stop bit completes.
  assign pop  = (t_state == T_STOP) && (t_cnt == '0) && (t_sel == LAST_BYTE);
  assign push = cpu_we && ((q_cnt != Q_CAP) || pop);
  assign head = q[q_rd];

  // Echo queue storage (no reset needed, guarded by q_cnt).
  always_ff @(posedge clock) begin
    if (push) q[q_wr] <= '{idx: 5'(cpu_idx), data: 16'(IO_write_data)};
  end

  // Echo queue pointers, occupancy and overflow sticky.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_wr        <= '0;
      q_rd        <= '0;
      q_cnt       <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (push) q_wr <= ptr_next(q_wr);
      if (pop) q_rd <= ptr_next(q_rd);
      if (push && !pop) q_cnt <= q_cnt + 1'b1;
      else if (!push && pop) q_cnt <= q_cnt - 1'b1;
      if (cpu_we && !push) tx_overflow <= 1'b1;
    end
  end

  // Select the frame byte currently being sent from the head entry.
  always_comb begin
    case (t_sel)
      2'd0:    cur_byte = frame_addr(head.idx);
      2'd1:    cur_byte = head.data[15:8];
      2'd2:    cur_byte = head.data[7:0];
      default: cur_byte = frame_addr(head.idx) ^ head.data[15:8] ^ head.data[7:0];
    endcase
  end

  // UART transmitter; byte loaded at end of start bit so a fresh head is seen.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      t_state <= T_IDLE;
      tx      <= 1'b1;
      t_cnt   <= '0;
      t_bit   <= '0;
      t_sel   <= '0;
      t_shift <= '0;
    end else begin
      case (t_state)
        T_IDLE: begin
          if (q_cnt != '0) begin
            tx      <= 1'b0;
            t_cnt   <= FULL;
            t_sel   <= '0;
            t_state <= T_START;
          end
        end
        T_START: begin
          if (t_cnt != '0) t_cnt <= t_cnt - 1'b1;
          else begin
            t_shift <= cur_byte;
            tx      <= cur_byte[0];
            t_bit   <= '0;
            t_cnt   <= FULL;
            t_state <= T_BITS;
          end
        end
        T_BITS: begin
          if (t_cnt != '0) t_cnt <= t_cnt - 1'b1;
          else begin
            t_cnt <= FULL;
            if (t_bit == 3'd7) begin
              tx      <= 1'b1;
              t_state <= T_STOP;
            end else begin
              tx      <= t_shift[1];
              t_shift <= {1'b1, t_shift[7:1]};
              t_bit   <= t_bit + 1'b1;
            end
          end
        end
        T_STOP: begin
          if (t_cnt != '0) t_cnt <= t_cnt - 1'b1;
          else if (t_sel == LAST_BYTE) begin
            t_sel <= '0;
            if (q_cnt > QC_W'(1) || push) begin
              tx      <= 1'b0;
              t_cnt   <= FULL;
              t_state <= T_START;
            end else t_state <= T_IDLE;
          end else begin
            t_sel   <= t_sel + 1'b1;
            tx      <= 1'b0;
            t_cnt   <= FULL;
            t_state <= T_START;
          end
        end
        default: t_state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_serial_bridge.sv
// Directed bench for io_serial_bridge (default 3-byte frame build).
module tb_io_serial_bridge;

  localparam int NR  = 8;
  localparam int DW  = 15;
  localparam int CPB = 4;
  localparam int SW  = $clog2(NR) + 1;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               rx = 1'b1;
  logic               tx;
  logic [SW-1:0]      IO_read_sel = '0;
  logic [DW-1:0]      IO_read_data;
  logic               IO_write_en = 1'b0;
  logic [SW-1:0]      IO_write_sel = '0;
  logic [DW-1:0]      IO_write_data = '0;
  logic [NR*DW-1:0]   regs_flat;
  logic               tx_overflow;
  logic               rx_frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  io_serial_bridge #(
    .NUM_REGS(NR), .DATA_W(DW), .CLKS_PER_BIT(CPB), .TXQ_DEPTH(4), .TIMEOUT_BITS(20)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rx            (rx),
    .tx            (tx),
    .IO_read_sel   (IO_read_sel),
    .IO_read_data  (IO_read_data),
    .IO_write_en   (IO_write_en),
    .IO_write_sel  (IO_write_sel),
    .IO_write_data (IO_write_data),
    .regs_flat     (regs_flat),
    .tx_overflow   (tx_overflow),
    .rx_frame_err  (rx_frame_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] reg_of(input int i);
    return regs_flat[i*DW +: DW];
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clock);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clock);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] h, input logic [7:0] l);
    send_byte(a);
    send_byte(h);
    send_byte(l);
  endtask

  task automatic cpu_write(input logic [SW-1:0] sel, input logic [DW-1:0] data);
    IO_write_en   = 1'b1;
    IO_write_sel  = sel;
    IO_write_data = data;
    @(negedge clock);
    IO_write_en   = 1'b0;
  endtask

  // Waits (bounded) for a start bit on tx, then samples 8 bits mid-bit.
  task automatic get_byte(output logic [7:0] b, output int t0);
    int n;
    n  = 0;
    b  = '0;
    t0 = -1;
    while (tx !== 1'b0 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk("tx_start_seen", {127'b0, tx}, 128'd0);
    if (tx !== 1'b0) return;
    t0 = cyc;
    repeat (CPB + CPB / 2) @(negedge clock);
    b[0] = tx;
    for (int i = 1; i < 8; i++) begin
      repeat (CPB) @(negedge clock);
      b[i] = tx;
    end
    repeat (CPB) @(negedge clock);
    chk("tx_stop_bit", {127'b0, tx}, 128'd1);
  endtask

  task automatic expect_tx_idle(input string tag, input int cycles);
    logic seen_low;
    seen_low = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clock);
      if (tx !== 1'b1) seen_low = 1'b1;
    end
    chk(tag, {127'b0, seen_low}, 128'd0);
  endtask

  logic [7:0] got [12];
  int         tstamp [12];
  logic [7:0] exp_bytes [12];

  initial begin
    logic [7:0] b;
    int t0, t1, t2;
    logic [NR*DW-1:0] exp_flat;

    // Reset state
    repeat (3) @(negedge clock);
    chk("rst_regs", 128'(regs_flat), 128'd0);
    chk("rst_tx", {127'b0, tx}, 128'd1);
    chk("rst_ovf", {127'b0, tx_overflow}, 128'd0);
    chk("rst_err", {127'b0, rx_frame_err}, 128'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Basic host write
    send_frame(8'hA1, 8'h2B, 8'h34);
    repeat (4) @(negedge clock);
    chk("host_reg1", 128'(reg_of(1)), 128'h2B34);
    chk("host_err0", {127'b0, rx_frame_err}, 128'd0);
    IO_read_sel = 4'd1;
    #1;
    chk("read_reg1", 128'(IO_read_data), 128'h2B34);
    IO_read_sel = 4'd9;
    #1;
    chk("read_oob", 128'(IO_read_data), 128'd0);

    // Inter-byte timeout returns parser to address state silently
    send_byte(8'hA4);
    send_byte(8'h11);
    repeat (100) @(negedge clock);
    chk("timeout_silent", {127'b0, rx_frame_err}, 128'd0);
    send_byte(8'h22);
    repeat (4) @(negedge clock);
    chk("timeout_bad_marker", {127'b0, rx_frame_err}, 128'd1);
    chk("timeout_reg4", 128'(reg_of(4)), 128'd0);

    // Bad index then recovery
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst2_err", {127'b0, rx_frame_err}, 128'd0);
    chk("rst2_regs", 128'(regs_flat), 128'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    send_frame(8'hA9, 8'h00, 8'h00);
    repeat (4) @(negedge clock);
    chk("bad_idx_err", {127'b0, rx_frame_err}, 128'd1);
    chk("bad_idx_regs", 128'(regs_flat), 128'd0);
    send_frame(8'hA2, 8'h00, 8'h05);
    repeat (4) @(negedge clock);
    chk("recover_reg2", 128'(reg_of(2)), 128'd5);

    // CPU write and its echo frame
    cpu_write(4'd3, 15'h1234);
    chk("cpu_reg3", 128'(reg_of(3)), 128'h1234);
    IO_read_sel = 4'd3;
    #1;
    chk("cpu_read3", 128'(IO_read_data), 128'h1234);
    get_byte(b, t0);
    chk("echo3_addr", 128'(b), 128'hA3);
    get_byte(b, t1);
    chk("echo3_hi", 128'(b), 128'h12);
    get_byte(b, t2);
    chk("echo3_lo", 128'(b), 128'h34);
    chk("echo3_gap1", 128'(t1 - t0), 128'd40);
    chk("echo3_gap2", 128'(t2 - t1), 128'd40);
    repeat (8) @(negedge clock);
    chk("echo3_ovf", {127'b0, tx_overflow}, 128'd0);

    // Out-of-range CPU write is ignored and not echoed
    cpu_write(4'd8, 15'h7777);
    exp_flat = '0;
    exp_flat[2*DW +: DW] = 15'd5;
    exp_flat[3*DW +: DW] = 15'h1234;
    chk("oob_write_regs", 128'(regs_flat), 128'(exp_flat));
    expect_tx_idle("oob_no_echo", 60);

    // Five back-to-back CPU writes overflow the 4-entry queue
    exp_bytes = '{8'hA0, 8'h7F, 8'hFF, 8'hA1, 8'h00, 8'h01,
                  8'hA4, 8'h4A, 8'hBC, 8'hA5, 8'h01, 8'h00};
    fork
      begin
        cpu_write(4'd0, 15'h7FFF);
        cpu_write(4'd1, 15'h0001);
        cpu_write(4'd4, 15'h4ABC);
        cpu_write(4'd5, 15'h0100);
        cpu_write(4'd6, 15'h2222);
        chk("burst_ovf", {127'b0, tx_overflow}, 128'd1);
        chk("burst_reg0", 128'(reg_of(0)), 128'h7FFF);
        chk("burst_reg1", 128'(reg_of(1)), 128'h0001);
        chk("burst_reg4", 128'(reg_of(4)), 128'h4ABC);
        chk("burst_reg5", 128'(reg_of(5)), 128'h0100);
        chk("burst_reg6", 128'(reg_of(6)), 128'h2222);
      end
      begin
        for (int i = 0; i < 12; i++) get_byte(got[i], tstamp[i]);
      end
    join
    for (int i = 0; i < 12; i++) chk($sformatf("burst_byte%0d", i), 128'(got[i]), 128'(exp_bytes[i]));
    chk("burst_frame_gap", 128'(tstamp[3] - tstamp[2]), 128'd40);
    expect_tx_idle("burst_no_fifth", 80);

    // Reset in the middle of a host frame
    send_byte(8'hA7);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    reset_n = 1'b0;
    rx = 1'b1;
    @(negedge clock);
    chk("midrst_regs", 128'(regs_flat), 128'd0);
    chk("midrst_tx", {127'b0, tx}, 128'd1);
    chk("midrst_ovf", {127'b0, tx_overflow}, 128'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(8'hA0, 8'h00, 8'h07);
    repeat (4) @(negedge clock);
    chk("post_rst_reg0", 128'(reg_of(0)), 128'd7);
    chk("post_rst_reg7", 128'(reg_of(7)), 128'd0);
    chk("post_rst_err", {127'b0, rx_frame_err}, 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
